// File: rtl/stc_pkg.sv
// Shared types and constants for the serial two's-complement engine.
// The optional parallel result port is enabled by defining STC_PARALLEL_OUT_EN.
package stc_pkg;

   typedef enum logic [1:0] {
      STC_IDLE  = 2'd0,
      STC_SHIFT = 2'd1,
      STC_DONE  = 2'd2
   } stc_state_e;

   localparam logic STC_MODE_NEG = 1'b0;
   localparam logic STC_MODE_ABS = 1'b1;

   // Abs mode negates only negative operands; negate mode always negates.
   function automatic logic stc_neg_sel(input logic mode, input logic sign);
      return (mode == STC_MODE_ABS) ? sign : 1'b1;
   endfunction

endpackage

// File: rtl/stc_shift_reg.sv
// Load/shift-right register with serial input at the MSB, asynchronous active-low reset.
// The full parallel output exists only when STC_PARALLEL_OUT_EN is defined.
module stc_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic             i_sin,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_lsb
`ifdef STC_PARALLEL_OUT_EN
   ,
   output logic [WIDTH-1:0] o_q
`endif
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_data;
      end else if (i_shift) begin
         r_q <= {i_sin, r_q[WIDTH-1:1]};
      end
   end

   assign o_lsb = r_q[0];
`ifdef STC_PARALLEL_OUT_EN
   assign o_q   = r_q;
`endif

endmodule

// File: rtl/serial_twos_comp_engine.sv
// Serial two's-complement negate/abs engine: parallel load, LSB-first serial result.
// Define STC_PARALLEL_OUT_EN to add the registered parallel result port.
module serial_twos_comp_engine
   import stc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             bit_valid,
   output logic             bit_out,
   output logic             done,
   output logic             ovf
`ifdef STC_PARALLEL_OUT_EN
   ,
   output logic [WIDTH-1:0] result
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] S_IDLE  = STC_IDLE;
   localparam logic [1:0] S_SHIFT = STC_SHIFT;
   localparam logic [1:0] S_DONE  = STC_DONE;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_seen;
   logic             r_neg;
   logic             r_ovf;

   logic             w_accept;
   logic             w_in_shift;
   logic             w_last;
   logic             w_neg_next;
   logic             w_sr_lsb;
   logic             w_bit;

   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_in_shift = (r_state == S_SHIFT);
   assign w_last     = w_in_shift && (r_cnt == LAST_CNT);
   assign w_neg_next = stc_neg_sel(mode, data[WIDTH-1]);
   // Bits up to and including the first 1 pass through; every later bit is inverted.
   assign w_bit      = w_sr_lsb ^ (r_seen & r_neg);

`ifdef STC_PARALLEL_OUT_EN
   logic [WIDTH-1:0] w_sr;
   logic [WIDTH-1:0] r_result;
`endif

   stc_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift_reg (
      .clk     (clk),
      .reset_b (reset_b),
      .i_load  (w_accept),
      .i_shift (w_in_shift),
      .i_sin   (w_bit),
      .i_data  (data),
      .o_lsb   (w_sr_lsb)
`ifdef STC_PARALLEL_OUT_EN
      ,
      .o_q     (w_sr)
`endif
   );

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_seen  <= 1'b0;
         r_neg   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_seen  <= 1'b0;
                  r_cnt   <= '0;
                  r_neg   <= w_neg_next;
                  r_ovf   <= w_neg_next && (data == MIN_NEG);
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_seen <= r_seen | w_sr_lsb;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef STC_PARALLEL_OUT_EN
   // Capture the register's post-shift value so result is valid in the done cycle.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_result <= '0;
      end else if (w_last) begin
         r_result <= {w_bit, w_sr[WIDTH-1:1]};
      end
   end

   assign result = r_result;
`endif

   assign busy      = (r_state != S_IDLE);
   assign bit_valid = w_in_shift;
   assign bit_out   = w_in_shift && w_bit;
   assign done      = (r_state == S_DONE);
   assign ovf       = (r_state == S_DONE) && r_ovf;

endmodule

// File: tb/tb_serial_twos_comp_engine.sv
// Bench for serial_twos_comp_engine: directed and random words against an arithmetic model,
// plus a WIDTH=2 instance for the narrowest legal width.
module tb_serial_twos_comp_engine;

   localparam int W  = 8;
   localparam int W2 = 2;

   logic          clk     = 1'b0;
   logic          reset_b = 1'b0;

   logic          start = 1'b0;
   logic          mode  = 1'b0;
   logic [W-1:0]  data  = '0;
   logic          busy, bit_valid, bit_out, done, ovf;
   logic [W-1:0]  result;

   logic          s2_start = 1'b0;
   logic          s2_mode  = 1'b0;
   logic [W2-1:0] s2_data  = '0;
   logic          s2_busy, s2_bit_valid, s2_bit_out, s2_done, s2_ovf;
   logic [W2-1:0] s2_result;

   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   logic          exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_twos_comp_engine #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .start     (start),
      .mode      (mode),
      .data      (data),
      .busy      (busy),
      .bit_valid (bit_valid),
      .bit_out   (bit_out),
      .done      (done),
      .ovf       (ovf)
`ifdef STC_PARALLEL_OUT_EN
      ,
      .result    (result)
`endif
   );

   serial_twos_comp_engine #(.WIDTH(W2)) u_dut2 (
      .clk       (clk),
      .reset_b   (reset_b),
      .start     (s2_start),
      .mode      (s2_mode),
      .data      (s2_data),
      .busy      (s2_busy),
      .bit_valid (s2_bit_valid),
      .bit_out   (s2_bit_out),
      .done      (s2_done),
      .ovf       (s2_ovf)
`ifdef STC_PARALLEL_OUT_EN
      ,
      .result    (s2_result)
`endif
   );

`ifndef STC_PARALLEL_OUT_EN
   assign result    = '0;
   assign s2_result = '0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: abs leaves non-negative operands alone; otherwise the result is 0 - operand mod 2^W.
   function automatic logic [W-1:0] ref_word(input logic [W-1:0] d, input logic m);
      logic [W-1:0] z;
      z = '0;
      if (m && !d[W-1]) return d;
      return z - d;
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] d, input logic m);
      logic [W-1:0] mn;
      mn = '0;
      mn[W-1] = 1'b1;
      return !(m && !d[W-1]) && (d == mn);
   endfunction

   task automatic wait_idle();
      for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
      check("idle_wait", busy, 0);
   endtask

   task automatic run_word(input logic [W-1:0] d, input logic m);
      logic [W-1:0] ew;
      logic         eo;
      wait_idle();
      ew = ref_word(d, m);
      eo = ref_ovf(d, m);
      for (int i = 0; i < W; i++) exp_q.push_back(ew[i]);
      start = 1'b1;
      data  = d;
      mode  = m;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
         check("bit_valid", bit_valid, 1);
         check("busy_shift", busy, 1);
         check("done_shift", done, 0);
         check("ovf_shift", ovf, 0);
         check("bit_out", bit_out, exp_q.pop_front());
         // Inputs wander while busy; none of it may reach the serial result.
         if (i < W - 1) begin
            start = 1'($urandom);
            data  = W'($urandom);
            mode  = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check("done_pulse", done, 1);
      check("done_ovf", ovf, eo);
      check("done_bit_valid", bit_valid, 0);
      check("done_busy", busy, 1);
`ifdef STC_PARALLEL_OUT_EN
      check("result", result, ew);
`endif
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_ovf", ovf, 0);
   endtask

   task automatic run_w2(input logic [W2-1:0] d, input logic m);
      logic [W2-1:0] ew;
      logic [W2-1:0] z;
      logic          eo;
      z  = '0;
      ew = (m && !d[W2-1]) ? d : z - d;
      eo = !(m && !d[W2-1]) && (d == 2'b10);
      for (int k = 0; k < 10 && s2_busy !== 1'b0; k++) @(negedge clk);
      check("w2_idle_wait", s2_busy, 0);
      s2_start = 1'b1;
      s2_data  = d;
      s2_mode  = m;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < W2; i++) begin
         check("w2_bit_valid", s2_bit_valid, 1);
         check("w2_bit_out", s2_bit_out, ew[i]);
         if (i == W2 - 1) s2_start = 1'b0;
         @(negedge clk);
      end
      check("w2_done", s2_done, 1);
      check("w2_ovf", s2_ovf, eo);
`ifdef STC_PARALLEL_OUT_EN
      check("w2_result", s2_result, ew);
`endif
      @(negedge clk);
      check("w2_post_done", s2_done, 0);
   endtask

   initial begin
      int t_prev;
      int k;
      t_prev = 0;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_bit_out", bit_out, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_result", result, 0);
      @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);

      // Directed words
      run_word(8'h0C, 1'b0);
      run_word(8'h80, 1'b0);
      run_word(8'h00, 1'b0);
      run_word(8'h05, 1'b1);
      run_word(8'hFB, 1'b1);
      run_word(8'h80, 1'b1);
      run_word(8'h7F, 1'b1);
      run_word(8'hFF, 1'b0);

      // Start held high: one word per W+2 cycles while inputs churn mid-word
      wait_idle();
      start = 1'b1;
      data  = 8'h01;
      mode  = 1'b0;
      for (int w = 0; w < 3; w++) begin
         k = 0;
         while (bit_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("hold_bit_valid", bit_valid, 1);
         if (w > 0) check("hold_period", cyc - t_prev, W + 2);
         t_prev = cyc;
         for (int i = 0; i < W; i++) exp_q.push_back(ref_word(8'h01, 1'b0) >> i);
         for (int i = 0; i < W; i++) begin
            check("hold_bit_out", bit_out, exp_q.pop_front());
            if (i < W - 1) begin
               data = W'($urandom);
               mode = 1'($urandom);
            end else begin
               data = 8'h01;
               mode = 1'b0;
            end
            @(negedge clk);
         end
         check("hold_done", done, 1);
      end
      start = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of a word
      wait_idle();
      start = 1'b1;
      data  = 8'h3C;
      mode  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("pre_rst_bit_valid", bit_valid, 1);
      reset_b = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_bit_valid", bit_valid, 0);
      check("arst_done", done, 0);
      check("arst_bit_out", bit_out, 0);
      @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);
      check("arst_no_done", done, 0);
      run_word(8'h01, 1'b0);

      // Random words with random idle gaps
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_word(W'($urandom), 1'($urandom));
      end

      // Narrowest width, every operand in both modes
      for (int d = 0; d < 4; d++) begin
         run_w2(W2'(d), 1'b0);
         run_w2(W2'(d), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
